// File: rtl/pipe_slice_chain_pkg.sv
// Shared helpers for the elastic pipeline chain.
package pipe_slice_chain_pkg;

  // Next occupancy value.
  // Moves by one only when exactly one of inc/dec is set, and saturates at 0 and max_cnt.
  function automatic int unsigned occ_next(int unsigned cnt, logic inc, logic dec,
                                           int unsigned max_cnt);
    int unsigned res;
    res = cnt;
    if (inc && !dec && cnt < max_cnt) begin
      res = cnt + 1;
    end else if (dec && !inc && cnt > 0) begin
      res = cnt - 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One elastic stage: valid/data registers with ready combine, synchronous flush
// and asynchronous active-low reset.
module pipe_slice #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             up_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // The stage can take new content when it is empty or when its content moves on this cycle.
  // The downstream stage also accepts in that second case.
  assign up_ready = !valid || dn_ready;

  // Valid bit: flush clears it, otherwise it follows upstream whenever the stage can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
    end
  end

  // Data register: loads only real upstream items, so a bubble never overwrites held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (up_ready && up_valid) begin
      data <= up_data;
    end
  end

endmodule

// File: rtl/pipe_slice_chain.sv
// Elastic delay line of DEPTH pipe_slice stages with bubble collapsing, flush
// and a registered occupancy counter.
module pipe_slice_chain
  import pipe_slice_chain_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_q;

  // Each stage keeps its own handshake nets. The ready path from out_ready_i back
  // to in_ready_o is therefore a plain chain of separate signals.
  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;
      logic             dn_ready;
      logic             up_ready;
      logic             vld;
      logic [WIDTH-1:0] dat;

      if (k == 0) begin : g_head
        assign up_valid = in_valid_i;
        assign up_data  = in_data_i;
      end else begin : g_link
        assign up_valid = g_stage[k-1].vld;
        assign up_data  = g_stage[k-1].dat;
      end

      if (k == DEPTH - 1) begin : g_tail
        assign dn_ready = out_ready_i;
      end else begin : g_next
        assign dn_ready = g_stage[k+1].up_ready;
      end

      pipe_slice #(
        .WIDTH(WIDTH)
      ) u_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush_i),
        .up_valid(up_valid),
        .up_data (up_data),
        .dn_ready(dn_ready),
        .up_ready(up_ready),
        .valid   (vld),
        .data    (dat)
      );
    end
  endgenerate

  assign in_ready_o  = g_stage[0].up_ready;
  assign out_valid_o = g_stage[DEPTH-1].vld;
  assign out_data_o  = g_stage[DEPTH-1].dat;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  // Occupancy counter tracks handshakes rather than a popcount of the valid bits.
  // A flush discards a simultaneous input, so the counter goes to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      count_q <= CNT_W'(occ_next(32'(count_q), in_xfer, out_xfer, DEPTH));
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_pipe_slice_chain.sv
// Directed bench for pipe_slice_chain.
// Instance a: WIDTH=8, DEPTH=3. Instance b: WIDTH=8, DEPTH=2.
module tb_pipe_slice_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_count;

  int checks   = 0;
  int failures = 0;

  pipe_slice_chain #(.WIDTH(8), .DEPTH(3)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (a_in_valid),
    .in_ready_o (a_in_ready),
    .in_data_i  (a_in_data),
    .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready),
    .out_data_o (a_out_data),
    .count_o    (a_count)
  );

  pipe_slice_chain #(.WIDTH(8), .DEPTH(2)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (b_in_valid),
    .in_ready_o (b_in_ready),
    .in_data_i  (b_in_data),
    .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready),
    .out_data_o (b_out_data),
    .count_o    (b_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_a_valid", 32'(a_out_valid), 0);
    check("rst_a_data",  32'(a_out_data),  0);
    check("rst_a_count", 32'(a_count),     0);
    check("rst_a_ready", 32'(a_in_ready),  1);
    check("rst_b_count", 32'(b_count),     0);
    check("rst_b_ready", 32'(b_in_ready),  1);
    rst_n = 1'b1;
    tick();

    // Streaming on a: items 1..16 back to back, each appears 3 cycles later
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc >= 3 && cyc - 3 < 16) begin
        check("stream_valid", 32'(a_out_valid), 1);
        check("stream_data",  32'(a_out_data),  32'(cyc - 2));
      end else begin
        check("stream_idle", 32'(a_out_valid), 0);
      end
      check("stream_in_ready", 32'(a_in_ready), 1);
      if (cyc < 16) begin
        a_in_valid = 1'b1;
        a_in_data  = 8'(cyc + 1);
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
    end
    check("stream_count_end", 32'(a_count), 0);

    // Back-pressure on a
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hA1; settle();
    check("bp_rdy_a1", 32'(a_in_ready), 1);
    tick();
    a_in_data = 8'hA2; settle();
    check("bp_rdy_a2", 32'(a_in_ready), 1);
    tick();
    a_in_data = 8'hA3; settle();
    check("bp_rdy_a3", 32'(a_in_ready), 1);
    tick();
    a_in_data = 8'hA4; settle();
    check("bp_full_rdy",   32'(a_in_ready),  0);
    check("bp_full_count", 32'(a_count),     3);
    check("bp_full_valid", 32'(a_out_valid), 1);
    check("bp_hold_a1",    32'(a_out_data),  32'h A1);
    tick();
    check("bp_hold_a1_2",  32'(a_out_data),  32'h A1);
    check("bp_count_2",    32'(a_count),     3);
    a_out_ready = 1'b1; settle();
    check("bp_pass_rdy",   32'(a_in_ready),  1);
    tick();
    a_in_valid = 1'b0;
    check("bp_out_a2",     32'(a_out_data),  32'h A2);
    check("bp_cnt_a2",     32'(a_count),     3);
    tick();
    check("bp_out_a3",     32'(a_out_data),  32'h A3);
    check("bp_cnt_a3",     32'(a_count),     2);
    tick();
    check("bp_out_a4",     32'(a_out_data),  32'h A4);
    check("bp_vld_a4",     32'(a_out_valid), 1);
    check("bp_cnt_a4",     32'(a_count),     1);
    tick();
    check("bp_drained",    32'(a_out_valid), 0);
    check("bp_cnt_0",      32'(a_count),     0);

    // Bubble collapse on a: a single item advances under a stalled output
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h77; settle();
    check("bub_rdy0", 32'(a_in_ready), 1);
    tick();
    a_in_valid = 1'b0; settle();
    check("bub_rdy1",   32'(a_in_ready),  1);
    check("bub_cnt1",   32'(a_count),     1);
    check("bub_vld1",   32'(a_out_valid), 0);
    tick();
    check("bub_rdy2",   32'(a_in_ready),  1);
    check("bub_vld2",   32'(a_out_valid), 0);
    tick();
    check("bub_rdy3",   32'(a_in_ready),  1);
    check("bub_vld3",   32'(a_out_valid), 1);
    check("bub_data",   32'(a_out_data),  32'h77);
    check("bub_cnt3",   32'(a_count),     1);
    a_out_ready = 1'b1;
    tick();
    check("bub_drain",  32'(a_out_valid), 0);
    check("bub_cnt0",   32'(a_count),     0);

    // Flush with simultaneous input on a
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hB1;
    tick();
    a_in_data = 8'hB2;
    tick();
    check("fl_pre_count", 32'(a_count), 2);
    flush = 1'b1; a_in_data = 8'h55;
    tick();
    flush = 1'b0; a_in_valid = 1'b0;
    check("fl_count", 32'(a_count),     0);
    check("fl_valid", 32'(a_out_valid), 0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fl_no_55", 32'(a_out_valid), 0);
    end

    // Full pass-through on b
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 8'hC1;
    tick();
    b_in_data = 8'hC2;
    tick();
    b_in_data = 8'hC3; settle();
    check("pt_count_full", 32'(b_count),    2);
    check("pt_rdy_stall",  32'(b_in_ready), 0);
    check("pt_head_c1",    32'(b_out_data), 32'h C1);
    b_out_ready = 1'b1; settle();
    check("pt_rdy_pass",   32'(b_in_ready), 1);
    tick();
    b_in_valid = 1'b0;
    check("pt_count_keep", 32'(b_count),    2);
    check("pt_out_c2",     32'(b_out_data), 32'h C2);
    tick();
    check("pt_out_c3",     32'(b_out_data), 32'h C3);
    check("pt_count_1",    32'(b_count),    1);
    tick();
    check("pt_empty",      32'(b_out_valid), 0);
    check("pt_count_0",    32'(b_count),     0);

    // Asynchronous reset with two items in flight on b
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 8'hD1;
    tick();
    b_in_data = 8'hD2;
    tick();
    b_in_valid = 1'b0;
    check("ar_pre_count", 32'(b_count),     2);
    check("ar_pre_valid", 32'(b_out_valid), 1);
    rst_n = 1'b0;
    settle();
    check("ar_valid", 32'(b_out_valid), 0);
    check("ar_count", 32'(b_count),     0);
    check("ar_ready", 32'(b_in_ready),  1);
    check("ar_data",  32'(b_out_data),  0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_after", 32'(b_out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
